// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, next-PC source codes and PC stage states.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_TRAP   = 2'b11;

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } pc_state_t;

endpackage

// File: rtl/npc_mux.sv
// Next-PC 4:1 select: {sel1,sel0} = 00 seq, 01 branch, 10 jump, 11 trap.
module npc_mux
    import cpu_pkg::*;
(
    input  logic            sel1,
    input  logic            sel0,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [XLEN-1:0] in3,
    input  logic [XLEN-1:0] in4,
    output logic [XLEN-1:0] npc
);

    always_comb begin
        unique case ({sel1, sel0})
            2'b00:   npc = in1;
            2'b01:   npc = in2;
            2'b10:   npc = in3;
            default: npc = in4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, redirect priority, pending-redirect buffer and
// the fetch handshake FSM towards instruction memory.
//   state | meaning
//   BOOT  | one cycle after reset, redirects ignored
//   FETCH | request outstanding for pc, waiting for imem_ready
//   STALL | no request; redirects load pc directly
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic            instr_valid,
    output logic [1:0]      next_sel
);

    pc_state_t       state, state_d;
    logic [XLEN-1:0] pc_d;
    logic [1:0]      sel_d;
    logic            pend_valid, pend_valid_d;
    logic [1:0]      pend_sel, pend_sel_d;
    logic [XLEN-1:0] pend_target, pend_target_d;

    logic            redir;
    logic [1:0]      redir_sel;
    logic [1:0]      mux_sel;
    logic [XLEN-1:0] npc;

    assign redir = trap | jump | branch_taken;

    always_comb begin
        if (trap)              redir_sel = NPC_TRAP;
        else if (jump)         redir_sel = NPC_JUMP;
        else if (branch_taken) redir_sel = NPC_BRANCH;
        else                   redir_sel = NPC_SEQ;
    end

    assign mux_sel = redir ? redir_sel : NPC_SEQ;

    npc_mux u_npc_mux (
        .sel1 (mux_sel[1]),
        .sel0 (mux_sel[0]),
        .in1  (pc + 32'd4),
        .in2  (branch_target & ALIGN_MASK),
        .in3  (jump_target & ALIGN_MASK),
        .in4  (TRAP_VEC & ALIGN_MASK),
        .npc  (npc)
    );

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        sel_d         = next_sel;
        pend_valid_d  = pend_valid;
        pend_sel_d    = pend_sel;
        pend_target_d = pend_target;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        case (state)
            BOOT: state_d = stall ? STALL : FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_valid  = ~(pend_valid | redir);
                    pend_valid_d = 1'b0;
                    // a redirect arriving with the completion is newer than the buffered one
                    if (redir || !pend_valid) begin
                        pc_d  = npc;
                        sel_d = mux_sel;
                    end else begin
                        pc_d  = pend_target;
                        sel_d = pend_sel;
                    end
                    state_d = stall ? STALL : FETCH;
                end else if (redir) begin
                    pend_valid_d  = 1'b1;
                    pend_sel_d    = redir_sel;
                    pend_target_d = npc;
                end
            end
            STALL: begin
                if (redir) begin
                    pc_d  = npc;
                    sel_d = redir_sel;
                end
                if (!stall) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            next_sel    <= NPC_SEQ;
            pend_valid  <= 1'b0;
            pend_sel    <= NPC_SEQ;
            pend_target <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            next_sel    <= sel_d;
            pend_valid  <= pend_valid_d;
            pend_sel    <= pend_sel_d;
            pend_target <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: inputs change and outputs are sampled on the falling edge.
module tb_pc_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic        instr_valid;
    logic [1:0]  next_sel;

    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .imem_req      (imem_req),
        .instr_valid   (instr_valid),
        .next_sel      (next_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; trap = 1'b0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_iv", {31'b0, instr_valid}, 32'd0);
        chk("rst_sel", {30'b0, next_sel}, 32'd0);

        // zero-wait sequential fetch
        step(); rst_n = 1'b1;
        step();
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        chk("seq_pc0", pc, 32'h0);
        chk("seq_iv0", {31'b0, instr_valid}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("seq_pc", pc, 32'(4 * i));
            chk("seq_iv", {31'b0, instr_valid}, 32'd1);
            chk("seq_sel", {30'b0, next_sel}, 32'd0);
        end

        // wrap: jump to FFFF_FFFC then sequential
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        #1 chk("jmp_iv", {31'b0, instr_valid}, 32'd0);
        step(); jump = 1'b0;
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        chk("wrap_presel", {30'b0, next_sel}, 32'd2);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_sel", {30'b0, next_sel}, 32'd0);

        // held fetch at 0x10 with a branch in the first wait cycle
        jump = 1'b1; jump_target = 32'h10;
        step(); jump = 1'b0;
        chk("hold_pc", pc, 32'h10);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        step(); branch_taken = 1'b0;
        chk("hold_pc1", pc, 32'h10);
        chk("hold_req1", {31'b0, imem_req}, 32'd1);
        step();
        chk("hold_pc2", pc, 32'h10);
        imem_ready = 1'b1;
        #1 chk("hold_iv", {31'b0, instr_valid}, 32'd0);
        step();
        chk("pend_pc", pc, 32'h200);
        chk("pend_sel", {30'b0, next_sel}, 32'd1);

        // all three redirects with ready high
        trap = 1'b1; jump = 1'b1; jump_target = 32'h300;
        branch_taken = 1'b1; branch_target = 32'h400;
        #1 chk("prio_iv", {31'b0, instr_valid}, 32'd0);
        step(); trap = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        chk("prio_pc", pc, 32'h100);
        chk("prio_sel", {30'b0, next_sel}, 32'd3);

        // pending branch overridden by jump in completing cycle
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        step(); branch_taken = 1'b0;
        imem_ready = 1'b1; jump = 1'b1; jump_target = 32'h300;
        #1 chk("ovr_iv", {31'b0, instr_valid}, 32'd0);
        step(); jump = 1'b0;
        chk("ovr_pc", pc, 32'h300);
        chk("ovr_sel", {30'b0, next_sel}, 32'd2);

        // stall during fetch at 0x20
        jump = 1'b1; jump_target = 32'h20;
        step(); jump = 1'b0;
        chk("st_pc", pc, 32'h20);
        imem_ready = 1'b0; stall = 1'b1;
        step();
        chk("st_req", {31'b0, imem_req}, 32'd1);
        chk("st_hold", pc, 32'h20);
        imem_ready = 1'b1;
        #1 chk("st_iv", {31'b0, instr_valid}, 32'd1);
        step();
        chk("st_pc2", pc, 32'h24);
        chk("st_req2", {31'b0, imem_req}, 32'd0);
        jump = 1'b1; jump_target = 32'h43;
        step(); jump = 1'b0;
        chk("st_jpc", pc, 32'h40);
        chk("st_jreq", {31'b0, imem_req}, 32'd0);
        chk("st_jsel", {30'b0, next_sel}, 32'd2);
        step();
        chk("st_idle", pc, 32'h40);
        chk("st_idsel", {30'b0, next_sel}, 32'd2);
        stall = 1'b0;
        step();
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_pc", pc, 32'h40);

        // reset mid-fetch with a pending branch
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
        step(); branch_taken = 1'b0;
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_sel", {30'b0, next_sel}, 32'd0);
        imem_ready = 1'b1;
        step(); rst_n = 1'b1;
        step();
        chk("re_req", {31'b0, imem_req}, 32'd1);
        chk("re_iv", {31'b0, instr_valid}, 32'd1);
        step();
        chk("re_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
